// File: rtl/audio_pkg.sv
// Shared types, default constants and the saturation helper for the audio stream fetcher.
package audio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_READ,
    ST_WAIT,
    ST_LATCH,
    ST_MIX
  } fetch_state_t;

  localparam int NCH_DEFAULT          = 4;
  localparam int ADDR_W_DEFAULT       = 20;
  localparam int DATA_W_DEFAULT       = 16;
  localparam int CLKS_PER_SAMPLE_44K1 = 1134;
  localparam int READ_WAIT_DEFAULT    = 1;

  // Clamp a signed value into the range of a width-bit two's complement number.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] value,
                                                  input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/audio_period_counter.sv
// Free-running sample period counter; sample_tick marks counter value 0.
// The first tick after reset comes one cycle after release.
module audio_period_counter
  import audio_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = CLKS_PER_SAMPLE_44K1
) (
  input  logic clk,
  input  logic reset_n,
  output logic sample_tick
);

  localparam int CNT_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_SAMPLE - 1);

  logic [CNT_W-1:0] cnt;
  logic             running;

  // Hold at 0 for the reset-release cycle so the tick stays low while in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      running <= 1'b0;
    end else begin
      running <= 1'b1;
      if (running) cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign sample_tick = running && (cnt == '0);

endmodule

// File: rtl/audio_stream_fetch.sv
// Multi-channel SRAM audio sample fetcher: one word read per playing channel per period.
// Define AUDIO_MIX_EN to build the saturating channel mixer driving mix_out.
module audio_stream_fetch
  import audio_pkg::*;
#(
  parameter int NCH             = NCH_DEFAULT,
  parameter int ADDR_W          = ADDR_W_DEFAULT,
  parameter int DATA_W          = DATA_W_DEFAULT,
  parameter int CLKS_PER_SAMPLE = CLKS_PER_SAMPLE_44K1,
  parameter int READ_WAIT       = READ_WAIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NCH-1:0]        start,
  input  logic [NCH-1:0]        stop,
  input  logic [NCH-1:0]        loop,
  input  logic [NCH*ADDR_W-1:0] base_addr,
  input  logic [NCH*ADDR_W-1:0] length,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic                  sram_rd,
  input  logic [DATA_W-1:0]     sram_data,
  output logic [NCH*DATA_W-1:0] sample_out,
  output logic [NCH-1:0]        playing,
  output logic [NCH-1:0]        done,
  output logic                  sample_tick,
  output logic [DATA_W-1:0]     mix_out
);

  generate
    if (NCH < 1 || NCH > 8) begin : g_bad_nch
      $error("audio_stream_fetch: NCH must be in 1..8");
    end
    if (NCH * (READ_WAIT + 3) + 2 >= CLKS_PER_SAMPLE) begin : g_bad_period
      $error("audio_stream_fetch: worst-case fetch pass does not fit in one sample period");
    end
  endgenerate

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NCH - 1);
  localparam logic [2:0]      WAIT_LAST = (READ_WAIT > 0) ? 3'(READ_WAIT - 1) : 3'd0;

  fetch_state_t      state, next_state;
  logic [CH_W-1:0]   ch;
  logic [2:0]        wait_cnt;
  logic [ADDR_W-1:0] offset   [NCH];
  logic [DATA_W-1:0] sample_q [NCH];
  logic [ADDR_W-1:0] cur_addr, addr_hold;
  logic              killed, restarted;
  logic [NCH-1:0]    start_ok, stop_eff, latch_hit;
  logic [NCH-1:0]    playing_q, done_q, fin_pend, fin_arm;

  audio_period_counter #(
    .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
  ) u_period (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_tick(sample_tick)
  );

  // A start on a zero-length channel is ignored; a valid start overrides a same-cycle stop.
  always_comb begin
    start_ok  = '0;
    latch_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      start_ok[i]  = start[i] && (length[i*ADDR_W +: ADDR_W] != '0);
      latch_hit[i] = (state == ST_LATCH) && (ch == CH_W'(i));
    end
  end

  assign stop_eff = stop & ~start_ok;
  assign cur_addr = base_addr[ch*ADDR_W +: ADDR_W] + offset[ch];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (sample_tick) next_state = ST_SCAN;
      ST_SCAN: begin
        if (playing_q[ch])       next_state = ST_READ;
        else if (ch == LAST_CH)  next_state = ST_MIX;
      end
      ST_READ:  next_state = (READ_WAIT == 0) ? ST_LATCH : ST_WAIT;
      ST_WAIT:  if (wait_cnt == WAIT_LAST) next_state = ST_LATCH;
      ST_LATCH: next_state = (ch == LAST_CH) ? ST_MIX : ST_SCAN;
      ST_MIX:   next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    sram_rd   = 1'b0;
    sram_addr = '0;
    case (state)
      ST_READ: begin
        sram_rd   = 1'b1;
        sram_addr = cur_addr;
      end
      ST_WAIT: sram_addr = addr_hold;
      default: ;
    endcase
  end

  // Per-fetch bookkeeping: killed drops the latch, restarted keeps the restart's offset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch        <= '0;
      wait_cnt  <= '0;
      addr_hold <= '0;
      killed    <= 1'b0;
      restarted <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (sample_tick) ch <= '0;
        ST_SCAN: begin
          wait_cnt  <= '0;
          restarted <= 1'b0;
          killed    <= stop_eff[ch];
          if (!playing_q[ch] && ch != LAST_CH) ch <= ch + CH_W'(1);
        end
        ST_READ, ST_WAIT: begin
          if (state == ST_READ) addr_hold <= cur_addr;
          else                  wait_cnt  <= wait_cnt + 3'd1;
          if (start_ok[ch]) begin
            restarted <= 1'b1;
            killed    <= 1'b0;
          end else if (stop_eff[ch]) begin
            killed <= 1'b1;
          end
        end
        ST_LATCH: if (ch != LAST_CH) ch <= ch + CH_W'(1);
        default: ;
      endcase
    end
  end

  // Finished channels keep their last sample until the MIX of the following pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      playing_q <= '0;
      done_q    <= '0;
      fin_pend  <= '0;
      fin_arm   <= '0;
      for (int i = 0; i < NCH; i++) begin
        offset[i]   <= '0;
        sample_q[i] <= '0;
      end
    end else begin
      done_q <= '0;
      if (state == ST_MIX) begin
        fin_arm  <= fin_pend;
        fin_pend <= '0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (state == ST_MIX && fin_arm[i] && !start_ok[i]) sample_q[i] <= '0;
        if (latch_hit[i] && !killed && !stop_eff[i]) sample_q[i] <= sram_data;
        if (start_ok[i]) begin
          offset[i]    <= '0;
          playing_q[i] <= 1'b1;
          fin_pend[i]  <= 1'b0;
          fin_arm[i]   <= 1'b0;
        end else if (stop_eff[i]) begin
          playing_q[i] <= 1'b0;
          sample_q[i]  <= '0;
        end else if (latch_hit[i] && !killed && !restarted) begin
          if (offset[i] + ADDR_W'(1) == length[i*ADDR_W +: ADDR_W]) begin
            if (loop[i]) begin
              offset[i] <= '0;
            end else begin
              playing_q[i] <= 1'b0;
              done_q[i]    <= 1'b1;
              fin_pend[i]  <= 1'b1;
            end
          end else begin
            offset[i] <= offset[i] + ADDR_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    sample_out = '0;
    for (int i = 0; i < NCH; i++) sample_out[i*DATA_W +: DATA_W] = sample_q[i];
  end

  assign playing = playing_q;
  assign done    = done_q;

`ifdef AUDIO_MIX_EN
  logic signed [DATA_W+2:0] mix_sum;
  logic        [DATA_W-1:0] mix_q;

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      if (playing_q[i]) mix_sum = mix_sum + (DATA_W+3)'(signed'(sample_q[i]));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              mix_q <= '0;
    else if (state == ST_MIX)  mix_q <= DATA_W'(saturate(32'(mix_sum), DATA_W));
  end

  assign mix_out = mix_q;
`else
  assign mix_out = '0;
`endif

endmodule

// File: tb/tb_audio_stream_fetch.sv
// Self-checking bench for audio_stream_fetch: directed scenarios plus randomized channel control
// checked pass by pass against a period-level reference model.
module tb_audio_stream_fetch;

  localparam int NCH = 2;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int CPS = 32;
  localparam int RW = 1;
`ifdef AUDIO_MIX_EN
  localparam bit MIX_EN = 1'b1;
`else
  localparam bit MIX_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NCH-1:0]        start, stop, loop;
  logic [NCH*ADDR_W-1:0] base_addr, length;
  logic [ADDR_W-1:0]     sram_addr;
  logic                  sram_rd;
  logic [DATA_W-1:0]     sram_data;
  logic [NCH*DATA_W-1:0] sample_out;
  logic [NCH-1:0]        playing, done;
  logic                  sample_tick;
  logic [DATA_W-1:0]     mix_out;

  logic [ADDR_W-1:0] tb_base [NCH];
  logic [ADDR_W-1:0] tb_len  [NCH];
  logic [DATA_W-1:0] sram_q = '0;

  int checks = 0;
  int errors = 0;

  // Reference model state, one step per sample period
  logic [NCH-1:0]    m_play, m_fin, exp_done;
  int                m_off [NCH];
  logic [DATA_W-1:0] m_sample [NCH];
  logic [DATA_W-1:0] exp_mix;
  int                exp_addrs [$];
  logic [ADDR_W-1:0] rd_log [$];
  logic [NCH-1:0]    done_log [$];

  audio_stream_fetch #(
    .NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLKS_PER_SAMPLE(CPS), .READ_WAIT(RW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop(loop),
    .base_addr(base_addr), .length(length), .sram_addr(sram_addr), .sram_rd(sram_rd),
    .sram_data(sram_data), .sample_out(sample_out), .playing(playing), .done(done),
    .sample_tick(sample_tick), .mix_out(mix_out)
  );

  always #5 clk = ~clk;

  assign base_addr = {tb_base[1], tb_base[0]};
  assign length    = {tb_len[1], tb_len[0]};
  assign sram_data = sram_q;

  // SRAM returns the low address bits one cycle after the read strobe
  always @(posedge clk) if (sram_rd) sram_q <= sram_addr[15:0];

  always @(negedge clk) begin
    if (sram_rd) rd_log.push_back(sram_addr);
    if (|done)   done_log.push_back(done);
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd"}, 32'(sram_rd), 0);
    checkOutput({tag, "_addr"}, 32'(sram_addr), 0);
    checkOutput({tag, "_sample"}, sample_out, 0);
    checkOutput({tag, "_playing"}, 32'(playing), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_tick"}, 32'(sample_tick), 0);
    checkOutput({tag, "_mix"}, 32'(mix_out), 0);
  endtask

  task automatic modelReset();
    m_play = '0;
    m_fin  = '0;
    for (int i = 0; i < NCH; i++) begin
      m_off[i]    = 0;
      m_sample[i] = '0;
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
    @(negedge clk);
    start = st;
    stop  = sp;
    @(negedge clk);
    start = '0;
    stop  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (st[i] && tb_len[i] != 0) begin
        m_play[i] = 1'b1;
        m_off[i]  = 0;
        m_fin[i]  = 1'b0;
      end else if (sp[i]) begin
        m_play[i]   = 1'b0;
        m_sample[i] = '0;
      end
    end
  endtask

  task automatic modelPass();
    logic [NCH-1:0] clear_now;
    int a;
    int sum;
    clear_now = m_fin;
    m_fin     = '0;
    exp_done  = '0;
    exp_addrs.delete();
    for (int i = 0; i < NCH; i++) begin
      if (m_play[i]) begin
        a = (int'(tb_base[i]) + m_off[i]) & 'hFFFFF;
        exp_addrs.push_back(a);
        m_sample[i] = 16'(a);
        if (m_off[i] + 1 == int'(tb_len[i])) begin
          if (loop[i]) m_off[i] = 0;
          else begin
            m_play[i]   = 1'b0;
            exp_done[i] = 1'b1;
            m_fin[i]    = 1'b1;
          end
        end else begin
          m_off[i]++;
        end
      end
    end
    sum = 0;
    for (int i = 0; i < NCH; i++) begin
      if (clear_now[i]) m_sample[i] = '0;
      if (m_play[i]) sum += int'($signed(m_sample[i]));
    end
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
    exp_mix = MIX_EN ? 16'(sum) : 16'h0000;
  endtask

  task automatic waitTick(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 3 * CPS);
    checkOutput(tag, 32'(sample_tick), 1);
  endtask

  task automatic waitRead();
    int n = 0;
    while (!sram_rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rd_seen", 32'(sram_rd), 1);
  endtask

  // Run one sample period and compare reads, done pulses, samples, flags and mix.
  task automatic doPeriod();
    int dc;
    waitTick("tick");
    rd_log.delete();
    done_log.delete();
    modelPass();
    repeat (16) @(negedge clk);
    checkOutput("rd_count", 32'(rd_log.size()), 32'(exp_addrs.size()));
    for (int k = 0; k < exp_addrs.size() && k < rd_log.size(); k++)
      checkOutput($sformatf("rd_addr%0d", k), 32'(rd_log[k]), 32'(exp_addrs[k]));
    for (int i = 0; i < NCH; i++) begin
      dc = 0;
      foreach (done_log[k]) if (done_log[k][i]) dc++;
      checkOutput($sformatf("done%0d", i), 32'(dc), 32'(exp_done[i]));
      checkOutput($sformatf("sample%0d", i), 32'(sample_out[i*DATA_W +: DATA_W]), 32'(m_sample[i]));
      checkOutput($sformatf("playing%0d", i), 32'(playing[i]), 32'(m_play[i]));
    end
    checkOutput("mix", 32'(mix_out), 32'(exp_mix));
  endtask

  initial begin
    reset_n = 1'b0;
    start   = '0;
    stop    = '0;
    loop    = '0;
    for (int i = 0; i < NCH; i++) begin
      tb_base[i] = '0;
      tb_len[i]  = '0;
    end
    modelReset();
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset_n = 1'b1;
    checkOutput("tick_at_release", 32'(sample_tick), 0);
    @(negedge clk);
    checkOutput("tick_after_release", 32'(sample_tick), 1);
    repeat (16) @(negedge clk);

    $display("[TB] single channel, no loop");
    tb_base[0] = 20'h00100;
    tb_len[0]  = 20'd3;
    applyStimulus(2'b01, 2'b00);
    repeat (3) doPeriod();
    checkOutput("single_last_sample", 32'(sample_out[15:0]), 32'h0102);
    doPeriod();

    $display("[TB] looping channel 1");
    tb_base[1] = 20'h00200;
    tb_len[1]  = 20'd2;
    loop[1]    = 1'b1;
    applyStimulus(2'b10, 2'b00);
    repeat (4) doPeriod();

    $display("[TB] both channels, restart, stop");
    tb_base[0] = 20'h00300;
    tb_len[0]  = 20'd4;
    loop[0]    = 1'b1;
    applyStimulus(2'b01, 2'b00);
    repeat (3) doPeriod();
    applyStimulus(2'b01, 2'b01);
    doPeriod();
    applyStimulus(2'b00, 2'b10);
    doPeriod();

    $display("[TB] stop during WAIT");
    waitTick("tick_stopwait");
    rd_log.delete();
    done_log.delete();
    waitRead();
    checkOutput("stopwait_addr", 32'(sram_addr), 32'((int'(tb_base[0]) + m_off[0]) & 'hFFFFF));
    @(negedge clk);
    stop = 2'b01;
    @(negedge clk);
    stop = 2'b00;
    repeat (12) @(negedge clk);
    checkOutput("stopwait_sample", 32'(sample_out[15:0]), 0);
    checkOutput("stopwait_playing", 32'(playing), 0);
    checkOutput("stopwait_done", 32'(done_log.size()), 0);
    checkOutput("stopwait_rd_count", 32'(rd_log.size()), 1);
    m_play[0]   = 1'b0;
    m_sample[0] = '0;

    $display("[TB] start with zero length");
    tb_len[1] = '0;
    applyStimulus(2'b10, 2'b00);
    doPeriod();

    $display("[TB] mixer saturation");
    tb_base[0] = 20'h07000;  tb_len[0] = 20'd1;  loop[0] = 1'b1;
    tb_base[1] = 20'h07000;  tb_len[1] = 20'd1;  loop[1] = 1'b1;
    applyStimulus(2'b11, 2'b00);
    doPeriod();
`ifdef AUDIO_MIX_EN
    checkOutput("mix_pos_sat", 32'(mix_out), 32'h7FFF);
`else
    checkOutput("mix_disabled", 32'(mix_out), 0);
`endif
    applyStimulus(2'b00, 2'b11);
    tb_base[0] = 20'h09000;
    tb_base[1] = 20'h09000;
    applyStimulus(2'b11, 2'b00);
    doPeriod();
`ifdef AUDIO_MIX_EN
    checkOutput("mix_neg_sat", 32'(mix_out), 32'h8000);
`else
    checkOutput("mix_disabled2", 32'(mix_out), 0);
`endif

    $display("[TB] reset during WAIT");
    waitTick("tick_resetwait");
    waitRead();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkAllZero("midreset");
    modelReset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    checkOutput("tick_at_release2", 32'(sample_tick), 0);
    @(negedge clk);
    checkOutput("tick_after_release2", 32'(sample_tick), 1);
    checkOutput("playing_after_reset", 32'(playing), 0);
    repeat (16) @(negedge clk);

    $display("[TB] randomized channel control");
    for (int r = 0; r < 16; r++) begin
      logic [NCH-1:0] st, sp;
      st = '0;
      sp = '0;
      for (int i = 0; i < NCH; i++) begin
        int act;
        act = $urandom_range(0, 3);
        if (act == 1 || act == 3) begin
          st[i]      = 1'b1;
          tb_base[i] = 20'($urandom_range(0, 20'hFFFFF));
          tb_len[i]  = 20'($urandom_range(m_play[i] ? 1 : 0, 4));
          loop[i]    = 1'($urandom_range(0, 1));
        end
        if (act >= 2) sp[i] = 1'b1;
      end
      applyStimulus(st, sp);
      repeat ($urandom_range(1, 3)) doPeriod();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_stream_fetch.md
Name: audio_stream_fetch

Overview:
- Multi-channel successor to the single-channel SRAM audio sample fetcher.
- Every sample period it walks the active channels and issues one SRAM word read per channel at base + offset. Each result lands in a per-channel sample register.
- Per-channel start/stop/loop control. Parametrised in channel count, address/data width, sample period and SRAM read latency.
- Sits between the SRAM controller and the audio codec interface / mixer.

Parameters:
- NCH, 4, number of playback channels (1..8)
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, sample width (signed two's complement)
- CLKS_PER_SAMPLE, 1134, clk cycles per sample period (50 MHz -> ~44.1 kHz)
- READ_WAIT, 1, cycles from sram_rd assertion until sram_data is valid (0..7)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  NCH  per-channel one-cycle pulse: load offset 0, set playing
- stop  in  NCH  per-channel one-cycle pulse: clear playing
- loop  in  NCH  per-channel level: wrap to offset 0 at end instead of finishing
- base_addr  in  NCH*ADDR_W  per-channel first word address (channel i at bits [i*ADDR_W +: ADDR_W])
- length  in  NCH*ADDR_W  per-channel sample count
- sram_addr  out  ADDR_W  SRAM word address
- sram_rd  out  1  SRAM read strobe
- sram_data  in  DATA_W  SRAM read data
- sample_out  out  NCH*DATA_W  per-channel current sample
- playing  out  NCH  per-channel active flag
- done  out  NCH  one-cycle pulse when a non-looping channel plays its last sample
- sample_tick  out  1  one-cycle pulse at start of each sample period
- mix_out  out  DATA_W  mixed output (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): all outputs 0; period counter 0; all offsets 0; FSM in IDLE.
- Period counter: counts 0..CLKS_PER_SAMPLE-1 and wraps. sample_tick=1 in the cycle the counter equals 0.
- FSM states: IDLE, SCAN, READ, WAIT, LATCH, MIX.
- IDLE: on sample_tick, set ch=0 and go to SCAN.
- SCAN: if playing[ch], go to READ. Otherwise, if ch==NCH-1 go to MIX, else ch++ and stay in SCAN (1 cycle per skipped channel).
- READ: sram_addr = base_addr[ch] + offset[ch] (modulo 2^ADDR_W); sram_rd=1. Go to WAIT, or directly to LATCH if READ_WAIT==0.
- WAIT: hold sram_addr; sram_rd=0; stay READ_WAIT-1 further cycles, then go to LATCH.
- LATCH: sample_out[ch] <= sram_data.
  - If offset[ch] == length[ch]-1: if loop[ch], offset <= 0; else playing[ch] <= 0 and done[ch] pulses this cycle.
  - Otherwise offset[ch]++.
  - Then, if ch==NCH-1 go to MIX, else ch++ and go to SCAN.
- MIX: update mix_out, then go to IDLE.
- sram_addr holds 0 outside READ/WAIT; sram_rd is high only in READ.
- Worst-case pass is NCH*(READ_WAIT+3)+2 cycles. It must be < CLKS_PER_SAMPLE; enforce with an elaboration-time check.
- start[i]: offset[i] <= 0 and playing[i] <= 1 in the next cycle, even if already playing (restart).
  - If start[i] arrives while ch==i is in READ/WAIT, the in-flight fetch still latches. Its offset update is overridden by the restart.
  - start with length[i]==0 is ignored.
- stop[i]: playing[i] <= 0 and sample_out[i] <= 0. If channel i is mid-fetch, the latch is suppressed.
- start[i] and stop[i] in the same cycle: start wins.
- When a channel finishes (done), sample_out[i] is cleared to 0 one sample period later, at the next MIX.
- base_addr, length and loop are sampled live, so software changes them only while the channel is stopped.

Optional Feature:
- Macro AUDIO_MIX_EN.
- Defined: in MIX, mix_out <= signed sum of all sample_out for playing channels, computed at DATA_W+3 bits and saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Not defined: mix_out is constant 0, no adder is built, and MIX is a single pass-through cycle.

Decomposition:
- Package audio_pkg: state enum type, default parameter constants (CLKS_PER_SAMPLE_44K1=1134), and a saturate function.
- Sub-module audio_period_counter: period counter producing sample_tick. Parameter CLKS_PER_SAMPLE; ports clk, reset_n, sample_tick.

Test Plan:
- Config for all tests: NCH=2, ADDR_W=20, DATA_W=16, CLKS_PER_SAMPLE=32, READ_WAIT=1; SRAM model returns data = addr[15:0] after 1 cycle.
- Reset mid-pass: assert reset_n=0 during WAIT -> all outputs 0 immediately; after release, sample_tick occurs 1 cycle later (counter 0) and no channel plays.
- Single channel: ch0 base=0x100, length=3, loop=0, start pulse -> reads 0x100, 0x101, 0x102 on three consecutive ticks; sample_out[0]=0x0100/0x0101/0x0102; done[0] pulses with the 0x102 latch; playing[0]=0 afterwards.
- Loop: ch1 base=0x200, length=2, loop=1 -> addresses 0x200, 0x201, 0x200, 0x201...; done[1] never pulses.
- Both channels active: ch0 read precedes ch1 read within a pass; sram_rd is high exactly 2 cycles per period.
- Start/stop in same cycle on ch0 -> ch0 plays from offset 0. stop alone mid-WAIT -> sample_out[0]=0 and no latch occurs. start with length=0 -> playing stays 0.
- With AUDIO_MIX_EN: both channels latch 0x7000 -> mix_out=0x7FFF (saturated); both latch 0x9000 -> mix_out=0x8000. Without the macro, mix_out stays 0.
